alu_exec_sequencer: RTL

//  Multi-cycle execute-stage controller for the 12-bit microcontroller.

---
 rtl/alu_exec_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_sequencer.sv
// ---------------------------------------------------------------------------
// alu_exec_sequencer
// Multi-cycle execute-stage controller for the 12-bit microcontroller.
// Takes one decoded instruction {opcode, addr} at a time. It fetches the
// memory operand, drives the external combinational ALU, and writes the
// result back to the accumulator, the status register or data memory.
// This block owns the Acc and Status registers.
//
// Ports
//   Clock, Reset_n         rising-edge clock, asynchronous active-low reset
//   Start, Instr           execute request; accepted only while idle
//   Busy, Done             busy from accept through the Done cycle; Done pulses in WB
//   MemAddr/MemRd/MemRdata data memory read (MemRdata valid the cycle after MemRd)
//   MemWr/MemWdata         data memory write strobe and data
//   AluEnable/AluMode      ALU enable (EX cycles) and operation select
//   AluOp1/AluOp2          ALU operands (Acc, memory operand)
//   AluCflags              incoming flags for the ALU (= Status)
//   AluResult/AluFlags     ALU outputs {Z,C,S,O}
//   Acc, Status            architectural accumulator and status flags
//
// Configuration macro: ALU_OUT_PIPE_EN
//   When defined, EX is split into EX1/EX2. The ALU outputs are captured at
//   the end of EX1 and moved to the write-back register at the end of EX2.
//   This adds one cycle to every latency.
// ---------------------------------------------------------------------------
module alu_exec_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int OPC_W  = 4
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic [11:0]       Instr,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemRd,
   input  logic [DATA_W-1:0] MemRdata,
   output logic              MemWr,
   output logic [DATA_W-1:0] MemWdata,
   output logic              AluEnable,
   output logic [OPC_W-1:0]  AluMode,
   output logic [DATA_W-1:0] AluOp1,
   output logic [DATA_W-1:0] AluOp2,
   output logic [3:0]        AluCflags,
   input  logic [DATA_W-1:0] AluResult,
   input  logic [3:0]        AluFlags,
   output logic [DATA_W-1:0] Acc,
   output logic [3:0]        Status
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_EX   = 3'd2,   // EX1 when the ALU output pipe is enabled
      S_EX2  = 3'd3,   // only entered when the ALU output pipe is enabled
      S_WB   = 3'd4
   } state_t;

   localparam logic [OPC_W-1:0] OPC_STORE = 4'b0010;
   localparam logic [OPC_W-1:0] OPC_LOAD  = 4'b0011;
   localparam logic [OPC_W-1:0] OPC_INC   = 4'b1000;
   localparam logic [OPC_W-1:0] OPC_DEC   = 4'b1001;
   localparam logic [OPC_W-1:0] OPC_NOT   = 4'b1111;

   // Opcodes that work on Acc alone and skip the memory read.
   function automatic logic is_nomem(input logic [OPC_W-1:0] opc);
      logic r;
      case (opc)
         OPC_INC, OPC_DEC, OPC_NOT: r = 1'b1;
         default:                   r = 1'b0;
      endcase
      return r;
   endfunction

   state_t              state_r;
   state_t              next_s;
   logic                accept_s;
   logic [OPC_W-1:0]    opc_r;
   logic [ADDR_W-1:0]   addr_r;
   logic                mem_op_r;
   logic [DATA_W-1:0]   op2_r;
   logic [DATA_W-1:0]   res_r;
   logic [3:0]          flg_r;
   logic [DATA_W-1:0]   acc_r;
   logic [3:0]          status_r;
   logic [DATA_W-1:0]   wdata_r;
   logic                busy_r;
   logic                done_r;
   logic                mem_rd_r;
   logic                mem_wr_r;
   logic                alu_en_r;
`ifdef ALU_OUT_PIPE_EN
   logic [DATA_W-1:0]   pipe_res_r;
   logic [3:0]          pipe_flg_r;
`endif

   assign accept_s = (state_r == S_IDLE) && Start;

   // Next-state decode for the execute sequence.
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (Start) begin
               next_s = is_nomem(Instr[11 -: OPC_W]) ? S_EX : S_RD;
            end else begin
               next_s = S_IDLE;
            end
         end
         S_RD: next_s = S_EX;
`ifdef ALU_OUT_PIPE_EN
         S_EX: next_s = S_EX2;
`else
         S_EX: next_s = S_WB;
`endif
         S_EX2: next_s = S_WB;
         S_WB:  next_s = S_IDLE;
         default: next_s = S_IDLE;
      endcase
   end

   // State register and strobes. The strobes are decoded from next_s so that
   // they come from flops and line up exactly with the state they belong to.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r  <= S_IDLE;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         mem_rd_r <= 1'b0;
         mem_wr_r <= 1'b0;
         alu_en_r <= 1'b0;
      end else begin
         state_r  <= next_s;
         busy_r   <= (next_s != S_IDLE);
         done_r   <= (next_s == S_WB);
         mem_rd_r <= (next_s == S_RD);
         mem_wr_r <= (next_s == S_WB) && (opc_r == OPC_STORE);
         alu_en_r <= (next_s == S_EX) || (next_s == S_EX2);
      end
   end

   // Instruction capture, operand capture, ALU result staging and write-back.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         opc_r    <= {OPC_W{1'b0}};
         addr_r   <= {ADDR_W{1'b0}};
         mem_op_r <= 1'b0;
         op2_r    <= {DATA_W{1'b0}};
         res_r    <= {DATA_W{1'b0}};
         flg_r    <= 4'b0000;
         acc_r    <= {DATA_W{1'b0}};
         status_r <= 4'b0000;
         wdata_r  <= {DATA_W{1'b0}};
`ifdef ALU_OUT_PIPE_EN
         pipe_res_r <= {DATA_W{1'b0}};
         pipe_flg_r <= 4'b0000;
`endif
      end else begin
         if (accept_s) begin
            opc_r    <= Instr[11 -: OPC_W];
            addr_r   <= Instr[ADDR_W-1:0];
            mem_op_r <= !is_nomem(Instr[11 -: OPC_W]);
         end
         if ((state_r == S_EX) && mem_op_r) begin
            op2_r <= MemRdata;
         end
`ifdef ALU_OUT_PIPE_EN
         if (state_r == S_EX) begin
            pipe_res_r <= AluResult;
            pipe_flg_r <= AluFlags;
         end
         if (state_r == S_EX2) begin
            res_r <= pipe_res_r;
            flg_r <= pipe_flg_r;
         end
`else
         if (state_r == S_EX) begin
            res_r <= AluResult;
            flg_r <= AluFlags;
         end
`endif
         if ((next_s == S_WB) && (opc_r == OPC_STORE)) begin
            wdata_r <= acc_r;
         end
         if (state_r == S_WB) begin
            case (opc_r)
               OPC_STORE: acc_r <= acc_r;
               OPC_LOAD:  acc_r <= res_r;
               default: begin
                  acc_r    <= res_r;
                  status_r <= flg_r;
               end
            endcase
         end
      end
   end

   // Read data arrives during the first EX cycle. It is forwarded straight to
   // the ALU in that cycle and is held in op2_r from then on.
   assign AluOp2 = ((state_r == S_EX) && mem_op_r) ? MemRdata : op2_r;

   assign Busy      = busy_r;
   assign Done      = done_r;
   assign MemAddr   = addr_r;
   assign MemRd     = mem_rd_r;
   assign MemWr     = mem_wr_r;
   assign MemWdata  = wdata_r;
   assign AluEnable = alu_en_r;
   assign AluMode   = opc_r;
   assign AluOp1    = acc_r;
   assign AluCflags = status_r;
   assign Acc       = acc_r;
   assign Status    = status_r;

endmodule
